shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter SHAMT_WIDTH, default 5, shift-amount width; DATA_WIDTH SHALL equal 2**SHAMT_WIDTH.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port IVALID  input  1  request valid.
REQ-006 SHALL have port IREADY  output  1  sequencer can accept a request.
REQ-007 SHALL have port IDATA  input  DATA_WIDTH  operand.
REQ-008 SHALL have port ISHAMT  input  SHAMT_WIDTH  shift amount, 0..DATA_WIDTH-1.
REQ-009 SHALL have port IOP  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 PASS.
REQ-010 SHALL have port OVALID  output  1  result valid.
REQ-011 SHALL have port OREADY  input  1  consumer accepts result.
REQ-012 SHALL have port ODATA  output  DATA_WIDTH  result.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IREADY SHALL be 1 only in IDLE; OVALID SHALL be 1 only in DONE.
REQ-015 In IDLE with IVALID=1, SHALL capture IDATA, ISHAMT, IOP into internal registers at the edge, clear stage counter to 0, and go to SHIFT.
REQ-016 In SHIFT, each cycle SHALL apply one log stage k (k = counter, 0..SHAMT_WIDTH-1): shift working register by 2**k if captured shamt[k]=1, else hold; counter increments.
REQ-017 SRL stage SHALL fill with zeros from MSB; SRA stage SHALL fill with sign bit of working register; SLL stage SHALL fill with zeros from LSB; PASS SHALL never modify the working register.
REQ-018 After stage SHAMT_WIDTH-1 is applied, SHALL go to DONE; latency from accepting edge to first OVALID=1 cycle is exactly SHAMT_WIDTH edges, independent of shamt or op (shamt 0 included).
REQ-019 ODATA SHALL be driven from the working register and stay stable while OVALID=1 and OREADY=0.
REQ-020 In DONE with OREADY=1, SHALL go to IDLE at that edge; a new request SHALL be accepted no earlier than the following cycle (no same-cycle output and input handshake).
REQ-021 IVALID, IDATA, ISHAMT, IOP SHALL be ignored outside IDLE.
REQ-022 Result SHALL equal the single-cycle reference: SRL x>>s, SRA signed x>>>s, SLL x<<s, PASS x.

Reset
REQ-023 With RST=1 at an edge, SHALL enter IDLE, clear counter and working register to 0; after that edge IREADY=1, OVALID=0, ODATA=0.
REQ-024 RST during SHIFT or DONE SHALL discard the in-flight operation with no OVALID pulse.
REQ-025 RST SHALL take priority over any concurrent handshake.

Structure
REQ-026 Shared package SHALL hold op encodings (OP_SRL, OP_SRA, OP_SLL, OP_PASS) and FSM state encoding.
REQ-027 One sub-module shift_stage SHALL implement a single runtime-selected stage (inputs: data, enable, direction, arithmetic flag, amount 2**k); the sequencer instantiates it once and reuses it every SHIFT cycle.

Verification
REQ-028 SRA: IDATA=0x80000000, ISHAMT=4 -> OVALID after 5 edges, ODATA=0xF8000000.
REQ-029 SRL: IDATA=0x80000000, ISHAMT=4 -> ODATA=0x08000000; SLL: IDATA=0x00000001, ISHAMT=31 -> ODATA=0x80000000.
REQ-030 ISHAMT=0, IOP=SRA, IDATA=0xDEADBEEF -> ODATA=0xDEADBEEF with same 5-edge latency; IOP=PASS, ISHAMT=7 -> ODATA unchanged.
REQ-031 Backpressure: OREADY=0 for 3 cycles in DONE -> ODATA constant, IREADY=0, IVALID pulses ignored; OREADY=1 -> IDLE next cycle, IREADY=1.
REQ-032 RST=1 at 2nd SHIFT cycle -> next cycle IREADY=1, OVALID=0, ODATA=0; no result for aborted request ever appears.
REQ-033 Random back-to-back requests (1000 ops, all ops, all shamts) -> every ODATA matches REQ-022 model, in order.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: op and FSM encodings shared by the shift sequencer
package shift_sequencer_pkg;
  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SLL  = 2'b10,
    OP_PASS = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// shift_stage: one runtime-selected log-shifter stage
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   en,
  input  logic                   left,
  input  logic                   arith,
  input  logic [SHAMT_WIDTH-1:0] amt,
  output logic [DATA_WIDTH-1:0]  res
);
  logic [DATA_WIDTH-1:0] sra;
  assign sra = $signed(data) >>> amt;
  always_comb res = !en ? data : left ? data << amt : arith ? sra : data >> amt;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter applying one log stage per cycle
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IVALID,
  output logic                   IREADY,
  input  logic [DATA_WIDTH-1:0]  IDATA,
  input  logic [SHAMT_WIDTH-1:0] ISHAMT,
  input  logic [1:0]             IOP,
  output logic                   OVALID,
  input  logic                   OREADY,
  output logic [DATA_WIDTH-1:0]  ODATA
);
  localparam logic [SHAMT_WIDTH-1:0] LAST = SHAMT_WIDTH'(SHAMT_WIDTH - 1);
  state_t                 state, state_n;
  op_t                    op;
  logic [SHAMT_WIDTH-1:0] cnt, shamt;
  logic [DATA_WIDTH-1:0]  work, nxt;
  always_comb begin
    state_n = state == IDLE  ? (IVALID ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == LAST ? DONE : SHIFT) :
              (OREADY ? IDLE : DONE);
  end
  assign IREADY = state == IDLE;
  assign OVALID = state == DONE;
  assign ODATA  = work;
  // shamt is consumed LSB-first so bit 0 always gates the current stage
  shift_stage #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH)) u_stage (
    .data  (work),
    .en    (shamt[0] && op != OP_PASS),
    .left  (op == OP_SLL),
    .arith (op == OP_SRA),
    .amt   (SHAMT_WIDTH'(1) << cnt),
    .res   (nxt)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      shamt <= '0;
      op    <= OP_SRL;
    end else begin
      state <= state_n;
      if (state == IDLE && IVALID) begin
        work  <= IDATA;
        shamt <= ISHAMT;
        op    <= op_t'(IOP);
        cnt   <= '0;
      end else if (state == SHIFT) begin
        work  <= nxt;
        shamt <= shamt >> 1;
        cnt   <= cnt + SHAMT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: random and directed checks against a behavioural shifter model
module tb_shift_sequencer;
  localparam int SW = 5;
  logic        CLK = 0, RST = 1, IVALID = 0, OREADY = 0;
  logic        IREADY, OVALID;
  logic [31:0] IDATA = 0, ODATA;
  logic [4:0]  ISHAMT = 0;
  logic [1:0]  IOP = 0;
  int errs = 0, checks = 0;
  int cyc = 0, vcyc = 0, acc_n = 0, done_n = 0, abort_n = 0;
  bit busy = 0, rst_pend = 0;
  logic [31:0] exp_d;

  shift_sequencer dut (
    .CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(IREADY), .IDATA(IDATA),
    .ISHAMT(ISHAMT), .IOP(IOP), .OVALID(OVALID), .OREADY(OREADY), .ODATA(ODATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_f(logic [31:0] x, logic [4:0] s, logic [1:0] o);
    case (o)
      2'b00:   return x >> s;
      2'b01:   return 32'($signed(x) >>> s);
      2'b10:   return x << s;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Model: one request in flight; result due SW+1 samples after the accepting sample
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      if (busy) abort_n++;
      busy = 0;
      rst_pend = 1;
    end else begin
      chk("iready", IREADY, !busy);
      chk("ovalid", OVALID, busy && cyc >= vcyc);
      if (rst_pend) chk("rst_odata", ODATA, 0);
      rst_pend = 0;
      if (OVALID && busy) chk("odata", ODATA, exp_d);
      if (OVALID && OREADY) begin
        busy = 0;
        done_n++;
      end else if (IREADY && IVALID) begin
        busy = 1;
        exp_d = ref_f(IDATA, ISHAMT, IOP);
        vcyc = cyc + 1 + SW;
        acc_n++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                       input logic [31:0] e, input int hold, input string nm);
    int n = 0;
    IVALID = 1; IDATA = d; ISHAMT = s; IOP = o;
    while (!IREADY && n < 50) begin tick(); n++; end
    tick();
    IVALID = 0; IDATA = $urandom;
    n = 0;
    while (!OVALID && n < 20) begin tick(); n++; end
    chk({nm, "_lat"}, n, SW);
    chk(nm, ODATA, e);
    for (int i = 0; i < hold; i++) begin
      IVALID = 1'($urandom); IDATA = $urandom; ISHAMT = 5'($urandom); IOP = 2'($urandom);
      tick();
      chk({nm, "_hold"}, ODATA, e);
      chk({nm, "_hold_irdy"}, IREADY, 0);
    end
    IVALID = 0;
    chk({nm, "_ov"}, OVALID, 1);
    OREADY = 1;
    tick();
    OREADY = 0;
    chk({nm, "_idle_irdy"}, IREADY, 1);
    chk({nm, "_idle_ov"}, OVALID, 0);
  endtask

  initial begin
    int n, target;
    repeat (3) tick();
    RST = 0;
    tick();
    chk("reset_irdy", IREADY, 1);
    chk("reset_ov", OVALID, 0);
    chk("reset_odata", ODATA, 0);
    do_op(32'h80000000, 4, 2'b01, 32'hF8000000, 3, "sra4");
    do_op(32'h80000000, 4, 2'b00, 32'h08000000, 0, "srl4");
    do_op(32'h00000001, 31, 2'b10, 32'h80000000, 1, "sll31");
    do_op(32'hDEADBEEF, 0, 2'b01, 32'hDEADBEEF, 0, "sra0");
    do_op(32'h12345678, 7, 2'b11, 32'h12345678, 0, "pass7");
    do_op(32'h7FFFFFFF, 31, 2'b01, 32'h00000000, 0, "sra31");
    do_op(32'hFFFFFFFF, 31, 2'b00, 32'h00000001, 2, "srl31");
    // abort in the second SHIFT cycle
    IVALID = 1; IDATA = 32'h80000000; ISHAMT = 4; IOP = 2'b01;
    tick();
    IVALID = 0;
    tick();
    RST = 1;
    tick();
    RST = 0;
    chk("abort_irdy", IREADY, 1);
    chk("abort_ov", OVALID, 0);
    chk("abort_odata", ODATA, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_ov", OVALID, 0);
    end
    target = acc_n + 1000;
    n = 0;
    while (acc_n < target && n < 40000) begin
      IVALID = ($urandom % 4) != 0;
      IDATA = $urandom; ISHAMT = 5'($urandom); IOP = 2'($urandom);
      OREADY = ($urandom % 3) != 0;
      tick();
      n++;
    end
    chk("random_budget", acc_n >= target, 1);
    IVALID = 0; OREADY = 1;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("drain", busy, 0);
    chk("count", done_n + abort_n, acc_n);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
